byte_link_rx: RTL and testbench

- Receive-side stage for the 8-bit bidirectional parallel link between host and server boards.
- The peer's PIO drives link_data. This block synchronises the peer's strobe and completes a 4-phase strobe/ack handshake per byte.
- Received bytes are buffered in a FIFO, which the local Nios reads through an Avalon-MM slave with 1-cycle registered read latency.
- An interrupt is raised while data is pending.

---
 rtl/byte_link_rx_if.sv | 24 ++
 rtl/byte_link_rx.sv | 146 ++++++++++++++
 tb/tb_byte_link_rx.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/byte_link_rx_if.sv
// Signal bundle for the byte link receiver: peer strobe/ack/data plus the Avalon-MM slave bus.
// The master modport is the driving side (peer PIO and Nios); the slave modport is the receiver.
interface byte_link_rx_if;
  logic [7:0]  link_data;
  logic        link_strobe;
  logic        link_ack;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output link_data, link_strobe, address, chipselect, read_n, write_n, writedata,
    input  link_ack, readdata, irq
  );

  modport slave (
    input  link_data, link_strobe, address, chipselect, read_n, write_n, writedata,
    output link_ack, readdata, irq
  );
endinterface

// File: rtl/byte_link_rx.sv
// Receive side of the host/server parallel byte link: synchronised strobe/ack handshake,
// byte FIFO, and an Avalon-MM register window with a level interrupt while data is pending.
module byte_link_rx #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  byte_link_rx_if.slave bus
);

  typedef enum logic {IDLE, ACKED} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t            state_q, state_d;
  logic              sync1_q, strobe_s_q;
  logic              ack_q, ack_d;
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              stall_q, stall_d;
  logic              irq_en_q, irq_q;
  logic [31:0]       readdata_q, readdata_d;

  logic full, empty, push, stall_set, rd_en, wr_en, pop, flush;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign rd_en = bus.chipselect && !bus.read_n;
  assign wr_en = bus.chipselect && !bus.write_n;
  assign pop   = rd_en && (bus.address == 2'd0) && !empty;
  assign flush = wr_en && (bus.address == 2'd2) && bus.writedata[1];

  // Only bits [2:0] of writedata carry meaning.
  logic unused_wdata;
  assign unused_wdata = ^bus.writedata[31:3];

  // Handshake FSM: one push per strobe-high period; a full FIFO simply withholds the ack.
  always_comb begin
    state_d   = state_q;
    ack_d     = ack_q;
    push      = 1'b0;
    stall_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (strobe_s_q) begin
          if (!full) begin
            push    = 1'b1;
            ack_d   = 1'b1;
            state_d = ACKED;
          end else begin
            stall_set = 1'b1;
          end
        end
      end
      ACKED: begin
        if (!strobe_s_q) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ack_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (flush)
      count_d = '0;
    else if (push && !pop)
      count_d = count_q + 1'b1;
    else if (pop && !push)
      count_d = count_q - 1'b1;
  end

  always_comb begin
    stall_d = stall_q;
    if (stall_set)
      stall_d = 1'b1;
    else if (wr_en && (bus.address == 2'd1) && bus.writedata[2])
      stall_d = 1'b0;
  end

  always_comb begin
    readdata_d = readdata_q;
    if (rd_en) begin
      unique case (bus.address)
        2'd0:    readdata_d = empty ? 32'd0 : {23'd0, 1'b1, mem_q[rd_ptr_q]};
        2'd1:    readdata_d = {16'd0, 8'(count_q), 5'd0, stall_q, full, empty};
        2'd2:    readdata_d = {30'd0, 1'b0, irq_en_q};
        default: readdata_d = 32'd0;
      endcase
    end
  end

  // Storage has no reset so it maps onto block RAM; a flush or reset only moves the pointers.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= bus.link_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b0;
      strobe_s_q <= 1'b0;
      ack_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      stall_q    <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
      readdata_q <= 32'd0;
    end else begin
      sync1_q    <= bus.link_strobe;
      strobe_s_q <= sync1_q;
      state_q    <= state_d;
      ack_q      <= ack_d;
      count_q    <= count_d;
      stall_q    <= stall_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_en_q && !empty;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push)
          wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)
          rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (wr_en && (bus.address == 2'd2))
        irq_en_q <= bus.writedata[0];
    end
  end

  assign bus.link_ack = ack_q;
  assign bus.readdata = readdata_q;
  assign bus.irq      = irq_q;

endmodule

// File: tb/tb_byte_link_rx.sv
// Directed bench for byte_link_rx: handshake timing, backpressure, wrap-around,
// coincident push/pop, interrupt, flush and mid-handshake reset.
module tb_byte_link_rx;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   passes = 0;

  byte_link_rx_if bus();

  byte_link_rx #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic wait_ack(input logic level, output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.link_ack === level) begin
        ok = 1'b1;
        cycles = i + 1;
        return;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] d, output bit ok);
    bit ok1, ok2;
    int c;
    @(negedge clk);
    bus.link_data   = d;
    bus.link_strobe = 1'b1;
    wait_ack(1'b1, ok1, c);
    bus.link_strobe = 1'b0;
    wait_ack(1'b0, ok2, c);
    ok = ok1 && ok2;
  endtask

  task automatic avalon_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.read_n     = 1'b0;
    @(negedge clk);
    d = bus.readdata;
    bus.chipselect = 1'b0;
    bus.read_n     = 1'b1;
  endtask

  task automatic avalon_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.link_ack, bus.irq, bus.readdata} !== 34'd0)
      $display("FAIL reset_outputs: got ack=%b irq=%b rd=%h required 0/0/0", bus.link_ack, bus.irq, bus.readdata);
    else passes++;
    reset_n = 1'b1;
    avalon_read(2'd1, rd);
    checks++;
    if (rd !== 32'h0000_0001) $display("FAIL reset_status: got %h required %h", rd, 32'h1);
    else passes++;
    avalon_read(2'd2, rd);
    checks++;
    if (rd !== 32'h0) $display("FAIL reset_control: got %h required 0", rd);
    else passes++;
    $display("test_reset done");
  endtask

  task automatic test_single_byte();
    bit ok;
    int c;
    logic [31:0] rd;
    @(negedge clk);
    bus.link_data   = 8'hA5;
    bus.link_strobe = 1'b1;
    wait_ack(1'b1, ok, c);
    checks++;
    if (!ok || c != 3) $display("FAIL ack_rise_latency: got ok=%0d cycles=%0d required 3", ok, c);
    else passes++;
    bus.link_strobe = 1'b0;
    wait_ack(1'b0, ok, c);
    checks++;
    if (!ok || c > 3) $display("FAIL ack_fall_latency: got ok=%0d cycles=%0d required <=3", ok, c);
    else passes++;
    avalon_read(2'd1, rd);
    checks++;
    if (rd !== 32'h0000_0100) $display("FAIL single_status: got %h required %h", rd, 32'h100);
    else passes++;
    avalon_read(2'd0, rd);
    checks++;
    if (rd !== 32'h0000_01A5) $display("FAIL single_data: got %h required %h", rd, 32'h1A5);
    else passes++;
    avalon_read(2'd1, rd);
    checks++;
    if (rd !== 32'h0000_0001) $display("FAIL single_empty: got %h required %h", rd, 32'h1);
    else passes++;
    $display("test_single_byte done");
  endtask

  task automatic test_fill_backpressure();
    bit ok;
    int c;
    logic [31:0] rd;
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i), ok);
      checks++;
      if (!ok) $display("FAIL fill_send: byte %0d handshake timed out, required completion", i);
      else passes++;
    end
    avalon_read(2'd1, rd);
    checks++;
    if (rd !== 32'h0000_1002) $display("FAIL fill_status: got %h required %h", rd, 32'h1002);
    else passes++;
    @(negedge clk);
    bus.link_data   = 8'h10;
    bus.link_strobe = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (bus.link_ack !== 1'b0) $display("FAIL full_no_ack: got %b required 0", bus.link_ack);
    else passes++;
    avalon_read(2'd1, rd);
    checks++;
    if (rd !== 32'h0000_1006) $display("FAIL stall_status: got %h required %h", rd, 32'h1006);
    else passes++;
    avalon_read(2'd0, rd);
    checks++;
    if (rd !== 32'h0000_0100) $display("FAIL full_pop: got %h required %h", rd, 32'h100);
    else passes++;
    wait_ack(1'b1, ok, c);
    checks++;
    if (!ok) $display("FAIL stalled_byte_ack: timed out, required ack after pop");
    else passes++;
    bus.link_strobe = 1'b0;
    wait_ack(1'b0, ok, c);
    for (int i = 1; i <= 16; i++) begin
      avalon_read(2'd0, rd);
      checks++;
      if (rd !== 32'h100 + 32'(i)) $display("FAIL drain_data: got %h required %h", rd, 32'h100 + 32'(i));
      else passes++;
    end
    avalon_read(2'd1, rd);
    checks++;
    if (rd !== 32'h0000_0005) $display("FAIL stall_sticky: got %h required %h", rd, 32'h5);
    else passes++;
    avalon_write(2'd1, 32'h4);
    avalon_read(2'd1, rd);
    checks++;
    if (rd !== 32'h0000_0001) $display("FAIL stall_clear: got %h required %h", rd, 32'h1);
    else passes++;
    $display("test_fill_backpressure done");
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    logic [7:0] d;
    logic [31:0] rd, exp;
    bit ok;
    for (int i = 0; i < 40; i++) begin
      d = 8'(i * 37 + 11);
      send_byte(d, ok);
      q.push_back(d);
      avalon_read(2'd1, rd);
      exp = {16'd0, 8'(q.size()), 7'd0, 1'b0};
      checks++;
      if (!ok || rd !== exp) $display("FAIL wrap_status: byte %0d ok=%0d got %h required %h", i, ok, rd, exp);
      else passes++;
      if (q.size() == 4) begin
        avalon_read(2'd0, rd);
        exp = {23'd0, 1'b1, q.pop_front()};
        checks++;
        if (rd !== exp) $display("FAIL wrap_data: got %h required %h", rd, exp);
        else passes++;
      end
    end
    while (q.size() != 0) begin
      avalon_read(2'd0, rd);
      exp = {23'd0, 1'b1, q.pop_front()};
      checks++;
      if (rd !== exp) $display("FAIL wrap_drain: got %h required %h", rd, exp);
      else passes++;
    end
    $display("test_wrap done");
  endtask

  task automatic test_back_to_back();
    bit ok;
    int c;
    logic [31:0] rd;
    for (int i = 0; i < 3; i++) send_byte(8'h51 + 8'(i), ok);
    @(negedge clk);
    bus.link_data   = 8'h54;
    bus.link_strobe = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.address    = 2'd0;
    bus.chipselect = 1'b1;
    bus.read_n     = 1'b0;
    @(negedge clk);
    rd = bus.readdata;
    bus.chipselect = 1'b0;
    bus.read_n     = 1'b1;
    checks++;
    if (rd !== 32'h151 || bus.link_ack !== 1'b1)
      $display("FAIL pushpop_same_edge: got rd=%h ack=%b required 151/1", rd, bus.link_ack);
    else passes++;
    bus.link_strobe = 1'b0;
    wait_ack(1'b0, ok, c);
    avalon_read(2'd1, rd);
    checks++;
    if (rd !== 32'h0000_0300) $display("FAIL pushpop_count: got %h required %h", rd, 32'h300);
    else passes++;
    for (int i = 2; i <= 4; i++) begin
      avalon_read(2'd0, rd);
      checks++;
      if (rd !== 32'h150 + 32'(i)) $display("FAIL pushpop_order: got %h required %h", rd, 32'h150 + 32'(i));
      else passes++;
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_empty_irq();
    bit ok;
    int c;
    logic [31:0] rd;
    avalon_read(2'd0, rd);
    checks++;
    if (rd !== 32'h0) $display("FAIL empty_read: got %h required 0", rd);
    else passes++;
    avalon_write(2'd2, 32'h1);
    @(negedge clk);
    checks++;
    if (bus.irq !== 1'b0) $display("FAIL irq_empty: got %b required 0", bus.irq);
    else passes++;
    @(negedge clk);
    bus.link_data   = 8'h3C;
    bus.link_strobe = 1'b1;
    wait_ack(1'b1, ok, c);
    @(negedge clk);
    checks++;
    if (bus.irq !== 1'b1) $display("FAIL irq_after_push: got %b required 1", bus.irq);
    else passes++;
    bus.link_strobe = 1'b0;
    wait_ack(1'b0, ok, c);
    avalon_read(2'd0, rd);
    checks++;
    if (rd !== 32'h13C || bus.irq !== 1'b1) $display("FAIL irq_read: got rd=%h irq=%b required 13c/1", rd, bus.irq);
    else passes++;
    @(negedge clk);
    checks++;
    if (bus.irq !== 1'b0) $display("FAIL irq_after_pop: got %b required 0", bus.irq);
    else passes++;
    avalon_write(2'd2, 32'h0);
    $display("test_empty_irq done");
  endtask

  task automatic test_flush_reset();
    bit ok;
    int c;
    logic [31:0] rd;
    for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i), ok);
    avalon_read(2'd1, rd);
    checks++;
    if (rd !== 32'h0000_0500) $display("FAIL flush_pre: got %h required %h", rd, 32'h500);
    else passes++;
    avalon_write(2'd2, 32'h2);
    avalon_read(2'd1, rd);
    checks++;
    if (rd !== 32'h0000_0001) $display("FAIL flush_status: got %h required %h", rd, 32'h1);
    else passes++;
    avalon_write(2'd2, 32'h1);
    @(negedge clk);
    bus.link_data   = 8'h77;
    bus.link_strobe = 1'b1;
    wait_ack(1'b1, ok, c);
    avalon_read(2'd2, rd);
    checks++;
    if (rd !== 32'h1 || bus.irq !== 1'b1) $display("FAIL pre_reset: got rd=%h irq=%b required 1/1", rd, bus.irq);
    else passes++;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.link_ack, bus.irq, bus.readdata} !== 34'd0)
      $display("FAIL async_reset: got ack=%b irq=%b rd=%h required 0/0/0", bus.link_ack, bus.irq, bus.readdata);
    else passes++;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    wait_ack(1'b1, ok, c);
    checks++;
    if (!ok) $display("FAIL repush_ack: timed out, required ack after reset release");
    else passes++;
    avalon_read(2'd1, rd);
    checks++;
    if (rd !== 32'h0000_0100) $display("FAIL repush_status: got %h required %h", rd, 32'h100);
    else passes++;
    avalon_read(2'd0, rd);
    checks++;
    if (rd !== 32'h177) $display("FAIL repush_data: got %h required %h", rd, 32'h177);
    else passes++;
    bus.link_strobe = 1'b0;
    wait_ack(1'b0, ok, c);
    $display("test_flush_reset done");
  endtask

  initial begin
    bus.link_data   = 8'h00;
    bus.link_strobe = 1'b0;
    bus.address     = 2'd0;
    bus.chipselect  = 1'b0;
    bus.read_n      = 1'b1;
    bus.write_n     = 1'b1;
    bus.writedata   = 32'd0;
    test_reset();
    test_single_byte();
    test_fill_backpressure();
    test_wrap();
    test_back_to_back();
    test_empty_irq();
    test_flush_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
